// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU data port (0)
// and a secondary master (1). One access cycle per grant, registered read data and ready.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ready0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ready1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  state_e              r_state;
  logic                r_last_grant;
  logic                r_owner;
  logic                r_we_l;
  logic [ADDR_W-3:0]   r_word_l;
  logic [DATA_W-1:0]   r_wdata_l;
  logic                r_mem_read;
  logic                r_mem_write;
  logic                r_ready0;
  logic                r_ready1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic                w_any_req;
  logic                w_grant;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_unused_addr_lsbs;

  // On a tie the port that did not win last time goes next; a lone request always wins.
  always_comb begin
    w_any_req = req0 | req1;
    w_grant   = 1'b0;
    if (req0 && req1) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = req1;
    end
    w_we    = w_grant ? we1    : we0;
    w_addr  = w_grant ? addr1  : addr0;
    w_wdata = w_grant ? wdata1 : wdata0;
  end

  // Memory is word addressed; byte offsets are dropped at the latch.
  assign w_unused_addr_lsbs = ^{addr0[1:0], addr1[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_we_l       <= 1'b0;
      r_word_l     <= '0;
      r_wdata_l    <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_ready0     <= 1'b0;
      r_ready1     <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_ready0    <= 1'b0;
      r_ready1    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_we_l       <= w_we;
            r_word_l     <= w_addr[ADDR_W-1:2];
            r_wdata_l    <= w_wdata;
            r_mem_read   <= ~w_we;
            r_mem_write  <= w_we;
            r_state      <= StAccess;
          end
        end
        StAccess: begin
          if (!r_we_l) begin
            if (r_owner) begin
              r_rdata1 <= mem_rdata;
            end else begin
              r_rdata0 <= mem_rdata;
            end
          end
          if (r_owner) begin
            r_ready1 <= 1'b1;
          end else begin
            r_ready0 <= 1'b1;
          end
          r_state <= StResp;
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = {r_word_l, 2'b00};
  assign mem_wdata = r_wdata_l;
  assign ready0    = r_ready0;
  assign ready1    = r_ready1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign busy      = (r_state != StIdle);
  assign owner     = r_owner;

  // Invariants: strobes only in ACCESS, never both; ready only in RESP, never both.
  a_strobe_excl : assert property (@(posedge clk) !(mem_read && mem_write));
  a_strobe_state : assert property (@(posedge clk)
    (mem_read || mem_write) |-> (r_state == StAccess));
  a_ready_excl : assert property (@(posedge clk) !(ready0 && ready1));
  a_ready_state : assert property (@(posedge clk)
    (ready0 || ready1) |-> (r_state == StResp));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table of single transactions plus hand-written
// tie, contention, same-address and reset-mid-access sequences against a 256x32 memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ready0, ready1, mem_read, mem_write, busy, owner;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  logic        unused_addr_bits;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ready0(ready0), .rdata0(rdata0), .ready1(ready1), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  assign unused_addr_bits = ^{mem_addr[31:10], mem_addr[1:0]};
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_maddr;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits up to 10 falling edges for a ready pulse; port = -1 if none arrived.
  task automatic wait_ready(output int port, output int cyc);
    port = -1;
    cyc  = 0;
    while (port < 0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (ready0 && ready1) begin
        n_cmp++;
        n_err++;
        $display("FAIL ready_both: got ready0=1 ready1=1 expected one");
      end
      if (ready0 || ready1) port = ready1 ? 1 : 0;
    end
    if (port < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: got no ready expected one within 10 cycles");
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready0"}, {31'd0, ready0}, 32'd0);
    chk({tag, "_ready1"}, {31'd0, ready1}, 32'd0);
    chk({tag, "_rdata0"}, rdata0, 32'd0);
    chk({tag, "_rdata1"}, rdata1, 32'd0);
    chk({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
    chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_owner"}, {31'd0, owner}, 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    int p, c, n_r0, n_r1;
    vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'h10,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h22,  32'h12345678, 32'h20,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h20,  32'h0,        32'h20,  32'hDEADBEEF, 32'h12345678};
    vecs[3] = '{1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'h3FC, 32'hDEADBEEF, 32'h12345678};
    vecs[4] = '{1'b0, 1'b0, 32'h3FC, 32'h0,        32'h3FC, 32'hCAFEF00D, 32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 32'h13,  32'h0,        32'h10,  32'hCAFEF00D, 32'hDEADBEEF};

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4] = 32'hDEADBEEF;

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Table: one transaction per row, checked at ACCESS, RESP and the following IDLE.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (vecs[i].port) begin
        req1 = 1'b1; we1 = vecs[i].we; addr1 = vecs[i].addr; wdata1 = vecs[i].wdata;
      end else begin
        req0 = 1'b1; we0 = vecs[i].we; addr0 = vecs[i].addr; wdata0 = vecs[i].wdata;
      end
      @(negedge clk);
      chk($sformatf("v%0d_mem_read", i), {31'd0, mem_read}, {31'd0, ~vecs[i].we});
      chk($sformatf("v%0d_mem_write", i), {31'd0, mem_write}, {31'd0, vecs[i].we});
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_maddr);
      chk($sformatf("v%0d_owner", i), {31'd0, owner}, {31'd0, vecs[i].port});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_early_ready", i), {30'd0, ready1, ready0}, 32'd0);
      if (vecs[i].we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].wdata);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {30'd0, ready1, ready0},
          vecs[i].port ? 32'd2 : 32'd1);
      chk($sformatf("v%0d_rdata0", i), rdata0, vecs[i].exp_r0);
      chk($sformatf("v%0d_rdata1", i), rdata1, vecs[i].exp_r1);
      chk($sformatf("v%0d_strobes_resp", i), {30'd0, mem_read, mem_write}, 32'd0);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_ready_off", i), {30'd0, ready1, ready0}, 32'd0);
      chk($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_addr_hold", i), mem_addr, vecs[i].exp_maddr);
    end
    chk("mem_word8", mem[8], 32'h12345678);
    chk("mem_word255", mem[255], 32'hCAFEF00D);

    // Tie right after reset: port 0 first, port 1 three cycles later.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    @(negedge clk);
    chk("tie_owner0", {31'd0, owner}, 32'd0);
    chk("tie_addr0", mem_addr, 32'h10);
    @(negedge clk);
    chk("tie_ready_first", {30'd0, ready1, ready0}, 32'd1);
    chk("tie_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 1'b0;
    @(negedge clk);
    chk("tie_gap_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("tie_owner1", {31'd0, owner}, 32'd1);
    chk("tie_addr1", mem_addr, 32'h20);
    @(negedge clk);
    chk("tie_ready_second", {30'd0, ready1, ready0}, 32'd2);
    chk("tie_rdata1", rdata1, 32'h12345678);

    // Continuous contention: both requests stay up with a fresh address after each ready.
    req0 = 1'b1; addr0 = 32'h0;
    req1 = 1'b1; addr1 = 32'h100;
    n_r0 = 0; n_r1 = 0;
    for (int k = 0; k < 8; k++) begin
      wait_ready(p, c);
      chk($sformatf("rr%0d_port", k), p, k % 2);
      chk($sformatf("rr%0d_spacing", k), c, 3);
      if (p == 0) begin
        n_r0++;
        addr0 = addr0 + 32'h4;
      end else if (p == 1) begin
        n_r1++;
        addr1 = addr1 + 32'h4;
      end
    end
    chk("rr_count0", n_r0, 4);
    chk("rr_count1", n_r1, 4);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Same-address hazard: write from port 0 and read from port 1 raised together.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'hA5A5A5A5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40;
    wait_ready(p, c);
    chk("haz_first_port", p, 0);
    chk("haz_first_lat", c, 2);
    req0 = 1'b0; we0 = 1'b0;
    wait_ready(p, c);
    chk("haz_second_port", p, 1);
    chk("haz_second_lat", c, 3);
    chk("haz_rdata1", rdata1, 32'hA5A5A5A5);
    chk("haz_mem", mem[16], 32'hA5A5A5A5);
    req1 = 1'b0;
    @(negedge clk);

    // Reset during ACCESS of a read: no ready, reset outputs, then reissue completes.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    @(negedge clk);
    chk("rst_in_access", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_mid");
    reset = 1'b0;
    wait_ready(p, c);
    chk("rst_reissue_port", p, 0);
    chk("rst_reissue_lat", c, 2);
    chk("rst_reissue_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
